// File: rtl/time_manager.sv
// rtl/time_manager.sv - emulation time manager: grants the minimum requested timestep, with run/halt-now/halt-at control
// Optional ceiling on the granted step is enabled by `define TM_DT_MAX_EN.
`ifndef DT_WIDTH
`define DT_WIDTH 32
`endif

module time_manager #(
  parameter int                    N_REQ      = 2,
  parameter int                    TIME_WIDTH = 64,
  parameter logic [`DT_WIDTH-1:0]  DT_MAX     = {`DT_WIDTH{1'b1}}
) (
  input  logic                         emu_clk,
  input  logic                         emu_rst,
  input  logic [N_REQ*`DT_WIDTH-1:0]   emu_dt_req,
  input  logic [1:0]                   emu_ctrl_mode,
  input  logic [TIME_WIDTH-1:0]        emu_ctrl_data,
  output logic [`DT_WIDTH-1:0]         emu_dt,
  output logic [TIME_WIDTH-1:0]        emu_time,
  output logic                         halted
);

  localparam int DW = `DT_WIDTH;

  localparam logic [1:0] MODE_HALT_NOW = 2'd1;
  localparam logic [1:0] MODE_HALT_AT  = 2'd2;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_ARMED  = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [TIME_WIDTH-1:0] emu_time_q, emu_time_d;

  logic [DW-1:0]         min_req;
  logic [DW-1:0]         min_eff;
  logic [DW-1:0]         halt_at_dt;
  logic [TIME_WIDTH-1:0] remaining;
  logic [TIME_WIDTH-1:0] min_eff_ext;
  logic [TIME_WIDTH-1:0] dt_ext;
  logic [TIME_WIDTH-1:0] time_next;
  logic                  target_passed;
  logic                  clamp_hit;
  logic                  target_hit;

  always_comb begin
    min_req = emu_dt_req[DW-1:0];
    for (int i = 1; i < N_REQ; i++) begin
      if (emu_dt_req[i*DW +: DW] < min_req) begin
        min_req = emu_dt_req[i*DW +: DW];
      end
    end
  end

`ifdef TM_DT_MAX_EN
  assign min_eff = (min_req > DT_MAX) ? DT_MAX : min_req;
`else
  assign min_eff = min_req;
`endif

  // Distance to the halt target is taken from the live emu_ctrl_data, so edits while armed act immediately.
  assign remaining     = emu_ctrl_data - emu_time_q;
  assign min_eff_ext   = {{(TIME_WIDTH-DW){1'b0}}, min_eff};
  assign target_passed = (emu_ctrl_data <= emu_time_q);
  assign clamp_hit     = (remaining < min_eff_ext);

  always_comb begin
    halt_at_dt = min_eff;
    if (target_passed) begin
      halt_at_dt = '0;
    end else if (clamp_hit) begin
      halt_at_dt = remaining[DW-1:0];
    end
  end

  always_ff @(posedge emu_clk) begin
    if (emu_rst) begin
      state_q    <= ST_RUN;
      emu_time_q <= '0;
    end else begin
      state_q    <= state_d;
      emu_time_q <= emu_time_d;
    end
  end

  assign dt_ext     = {{(TIME_WIDTH-DW){1'b0}}, emu_dt};
  assign time_next  = emu_time_q + dt_ext;
  assign target_hit = target_passed || (time_next == emu_ctrl_data);
  assign emu_time_d = time_next;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN, ST_ARMED: begin
        if (emu_ctrl_mode == MODE_HALT_NOW) begin
          state_d = ST_HALTED;
        end else if (emu_ctrl_mode == MODE_HALT_AT) begin
          state_d = target_hit ? ST_HALTED : ST_ARMED;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_HALTED: begin
        if (emu_ctrl_mode == MODE_HALT_AT) begin
          if (!target_passed) begin
            state_d = ST_ARMED;
          end
        end else if (emu_ctrl_mode != MODE_HALT_NOW) begin
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  // The clamp applies only while mode is HALT_AT; leaving ARMED via RUN grants the plain minimum.
  always_comb begin
    emu_dt = '0;
    if (!emu_rst) begin
      case (state_q)
        ST_RUN, ST_ARMED: begin
          if (emu_ctrl_mode == MODE_HALT_NOW) begin
            emu_dt = '0;
          end else if (emu_ctrl_mode == MODE_HALT_AT) begin
            emu_dt = halt_at_dt;
          end else begin
            emu_dt = min_eff;
          end
        end
        default: emu_dt = '0;
      endcase
    end
  end

  assign emu_time = emu_time_q;
  assign halted   = (state_q == ST_HALTED);

endmodule

// File: tb/tb_time_manager.sv
// tb/tb_time_manager.sv - directed self-checking bench for time_manager
`ifndef DT_WIDTH
`define DT_WIDTH 32
`endif

module tb_time_manager;

  localparam int DW = `DT_WIDTH;
  localparam int TW = 64;

  logic            clk = 1'b0;
  logic            rst;
  logic [2*DW-1:0] req;
  logic [1:0]      mode;
  logic [TW-1:0]   data;
  logic [DW-1:0]   dt;
  logic [TW-1:0]   tm;
  logic            halted;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  time_manager #(
    .N_REQ      (2),
    .TIME_WIDTH (TW),
    .DT_MAX     (8)
  ) dut (
    .emu_clk       (clk),
    .emu_rst       (rst),
    .emu_dt_req    (req),
    .emu_ctrl_mode (mode),
    .emu_ctrl_data (data),
    .emu_dt        (dt),
    .emu_time      (tm),
    .halted        (halted)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_reqs(input longint unsigned r0, input longint unsigned r1);
    req[0 +: DW]  = DW'(r0);
    req[DW +: DW] = DW'(r1);
  endtask

  task automatic test_reset();
    rst = 1'b1; mode = 2'd0; data = '0;
    set_reqs(5, 7);
    tick();
    #1;
    total++; if (dt !== DW'(0)) begin bad++; $display("FAIL reset_dt: got %0d want 0", dt); end
    tick();
    total++; if (tm !== TW'(0)) begin bad++; $display("FAIL reset_time: got %0d want 0", tm); end
    total++; if (halted !== 1'b0) begin bad++; $display("FAIL reset_halted: got %b want 0", halted); end
  endtask

  task automatic test_run();
    rst = 1'b0; mode = 2'd0;
    set_reqs(40, 25);
    for (int i = 0; i < 4; i++) begin
      #1;
      total++; if (dt !== DW'(25)) begin bad++; $display("FAIL run_dt[%0d]: got %0d want 25", i, dt); end
      tick();
    end
    total++; if (tm !== TW'(100)) begin bad++; $display("FAIL run_time: got %0d want 100", tm); end
  endtask

  task automatic test_halt_at();
    longint unsigned exp_dt [5] = '{10, 10, 10, 5, 0};
    longint unsigned exp_tm [5] = '{10, 20, 30, 35, 35};
    logic            exp_h  [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++; if (tm !== TW'(0)) begin bad++; $display("FAIL halt_at_start_time: got %0d want 0", tm); end
    mode = 2'd2; data = TW'(35);
    set_reqs(10, 10);
    for (int i = 0; i < 5; i++) begin
      #1;
      total++; if (dt !== DW'(exp_dt[i])) begin bad++; $display("FAIL halt_at_dt[%0d]: got %0d want %0d", i, dt, exp_dt[i]); end
      tick();
      total++; if (tm !== TW'(exp_tm[i])) begin bad++; $display("FAIL halt_at_time[%0d]: got %0d want %0d", i, tm, exp_tm[i]); end
      total++; if (halted !== exp_h[i]) begin bad++; $display("FAIL halt_at_halted[%0d]: got %b want %b", i, halted, exp_h[i]); end
    end
  endtask

  task automatic test_resume();
    mode = 2'd0;
    set_reqs(7, 9);
    #1;
    total++; if (dt !== DW'(0)) begin bad++; $display("FAIL resume_halted_dt: got %0d want 0", dt); end
    tick();
    total++; if (halted !== 1'b0) begin bad++; $display("FAIL resume_halted: got %b want 0", halted); end
    #1;
    total++; if (dt !== DW'(7)) begin bad++; $display("FAIL resume_dt: got %0d want 7", dt); end
    tick();
    total++; if (tm !== TW'(42)) begin bad++; $display("FAIL resume_time: got %0d want 42", tm); end
  endtask

  task automatic test_halt_past();
    set_reqs(8, 8);
    tick();
    total++; if (tm !== TW'(50)) begin bad++; $display("FAIL past_setup_time: got %0d want 50", tm); end
    mode = 2'd2; data = TW'(20);
    #1;
    total++; if (dt !== DW'(0)) begin bad++; $display("FAIL past_dt: got %0d want 0", dt); end
    tick();
    total++; if (halted !== 1'b1) begin bad++; $display("FAIL past_halted: got %b want 1", halted); end
    tick();
    total++; if (tm !== TW'(50)) begin bad++; $display("FAIL past_time: got %0d want 50", tm); end
    total++; if (halted !== 1'b1) begin bad++; $display("FAIL past_stay_halted: got %b want 1", halted); end
  endtask

  task automatic test_halt_now();
    mode = 2'd0;
    set_reqs(30, 30);
    tick();
    #1;
    total++; if (dt !== DW'(30)) begin bad++; $display("FAIL now_run_dt: got %0d want 30", dt); end
    tick();
    total++; if (tm !== TW'(80)) begin bad++; $display("FAIL now_run_time: got %0d want 80", tm); end
    mode = 2'd1;
    #1;
    total++; if (dt !== DW'(0)) begin bad++; $display("FAIL now_dt: got %0d want 0", dt); end
    tick();
    total++; if (halted !== 1'b1) begin bad++; $display("FAIL now_halted: got %b want 1", halted); end
    total++; if (tm !== TW'(80)) begin bad++; $display("FAIL now_time: got %0d want 80", tm); end
    rst = 1'b1;
    tick();
    rst = 1'b0; mode = 2'd0;
    total++; if (tm !== TW'(0)) begin bad++; $display("FAIL now_rst_time: got %0d want 0", tm); end
    total++; if (halted !== 1'b0) begin bad++; $display("FAIL now_rst_halted: got %b want 0", halted); end
    #1;
    total++; if (dt !== DW'(30)) begin bad++; $display("FAIL now_rst_run_dt: got %0d want 30", dt); end
    tick();
  endtask

  task automatic test_zero_and_min();
    set_reqs(0, 0);
    #1;
    total++; if (dt !== DW'(0)) begin bad++; $display("FAIL zero_dt: got %0d want 0", dt); end
    tick();
    total++; if (tm !== TW'(30)) begin bad++; $display("FAIL zero_time: got %0d want 30", tm); end
    total++; if (halted !== 1'b0) begin bad++; $display("FAIL zero_halted: got %b want 0", halted); end
    set_reqs(64'h8000_0000, 5);
    #1;
    total++; if (dt !== DW'(5)) begin bad++; $display("FAIL min_unsigned_dt: got %0d want 5", dt); end
    tick();
    set_reqs(3, 200);
    #1;
    total++; if (dt !== DW'(3)) begin bad++; $display("FAIL min_slot0_dt: got %0d want 3", dt); end
    tick();
    total++; if (tm !== TW'(38)) begin bad++; $display("FAIL min_time: got %0d want 38", tm); end
  endtask

  task automatic test_armed_edit();
    mode = 2'd2; data = TW'(1038);
    set_reqs(20, 20);
    #1;
    total++; if (dt !== DW'(20)) begin bad++; $display("FAIL edit_arm_dt: got %0d want 20", dt); end
    tick();
    total++; if (halted !== 1'b0) begin bad++; $display("FAIL edit_arm_halted: got %b want 0", halted); end
    data = TW'(63);
    #1;
    total++; if (dt !== DW'(5)) begin bad++; $display("FAIL edit_dt: got %0d want 5", dt); end
    tick();
    total++; if (tm !== TW'(63)) begin bad++; $display("FAIL edit_time: got %0d want 63", tm); end
    total++; if (halted !== 1'b1) begin bad++; $display("FAIL edit_halted: got %b want 1", halted); end
  endtask

  task automatic test_armed_exit();
    mode = 2'd2; data = TW'(1063);
    set_reqs(10, 10);
    #1;
    total++; if (dt !== DW'(0)) begin bad++; $display("FAIL rearm_dt: got %0d want 0", dt); end
    tick();
    total++; if (halted !== 1'b0) begin bad++; $display("FAIL rearm_halted: got %b want 0", halted); end
    mode = 2'd0; data = TW'(66);
    #1;
    total++; if (dt !== DW'(10)) begin bad++; $display("FAIL exit_noclamp_dt: got %0d want 10", dt); end
    tick();
    total++; if (tm !== TW'(73)) begin bad++; $display("FAIL exit_time: got %0d want 73", tm); end
    mode = 2'd2; data = TW'(1000);
    tick();
    mode = 2'd1;
    #1;
    total++; if (dt !== DW'(0)) begin bad++; $display("FAIL armed_now_dt: got %0d want 0", dt); end
    tick();
    total++; if (halted !== 1'b1) begin bad++; $display("FAIL armed_now_halted: got %b want 1", halted); end
    total++; if (tm !== TW'(83)) begin bad++; $display("FAIL armed_now_time: got %0d want 83", tm); end
  endtask

  task automatic test_dt_max();
    longint unsigned exp;
`ifdef TM_DT_MAX_EN
    exp = 8;
`else
    exp = 12;
`endif
    mode = 2'd0;
    set_reqs(20, 12);
    tick();
    #1;
    total++; if (dt !== DW'(exp)) begin bad++; $display("FAIL dt_max_dt: got %0d want %0d", dt, exp); end
    tick();
    total++; if (tm !== TW'(83 + exp)) begin bad++; $display("FAIL dt_max_time: got %0d want %0d", tm, 83 + exp); end
  endtask

  initial begin
    test_reset();
    test_run();
    test_halt_at();
    test_resume();
    test_halt_past();
    test_halt_now();
    test_zero_and_min();
    test_armed_edit();
    test_armed_exit();
    test_dt_max();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
